// File: rtl/reflex_timer_gen.sv
// Reaction-time game: arm, wait a pseudo-random delay, then time the fire press in BCD ms.
// Drives a multiplexed 7-segment display and a bank of status LEDs.
module reflex_timer_gen #(
    parameter int unsigned CYC_PER_MS    = 100000,
    parameter int unsigned DIGITS        = 3,
    parameter int unsigned DELAY_MIN_MS  = 1000,
    parameter int unsigned DELAY_STEP_MS = 1000,
    parameter int unsigned DELAY_STEPS   = 4,
    parameter int unsigned SCAN_CYC      = 32768
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready_click,
    input  logic              fire_click,
    output logic [DIGITS-1:0] anodes,
    output logic [7:0]        cathodes,
    output logic [7:0]        outleds,
    output logic              result_valid
);

    localparam int unsigned KWidth   = $clog2(DELAY_STEPS);
    localparam int unsigned PreW     = $clog2(CYC_PER_MS);
    localparam int unsigned DelayMax = DELAY_MIN_MS + (DELAY_STEPS - 1) * DELAY_STEP_MS;
    localparam int unsigned ElapsedW = $clog2(DelayMax + 1);
    localparam int unsigned ScanW    = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
    localparam int unsigned SelW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned BcdW     = 4 * DIGITS;

    localparam logic [BcdW-1:0] AllNines = {DIGITS{4'h9}};
    localparam logic [BcdW-1:0] AllBlank = {DIGITS{4'hA}};
    localparam logic [15:0]     LfsrSeed = 16'hACE1;

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StArm  = 3'd1;
    localparam logic [2:0] StWait = 3'd2;
    localparam logic [2:0] StGo   = 3'd3;
    localparam logic [2:0] StDone = 3'd4;
    localparam logic [2:0] StFoul = 3'd5;

    logic [2:0]          state_q, state_d;
    logic [15:0]         lfsr_q;
    logic [KWidth-1:0]   k_q, k_d;
    logic [PreW-1:0]     presc_q, presc_d;
    logic [ElapsedW-1:0] elapsed_q, elapsed_d;
    logic [BcdW-1:0]     bcd_q, bcd_d;
    logic [BcdW-1:0]     cap_q, cap_d;
    logic [BcdW-1:0]     best_q, best_d;
    logic                new_best_q, new_best_d;
    logic [ScanW-1:0]    scan_q;
    logic [SelW-1:0]     sel_q;
    logic [7:0]          cathodes_q;

    logic                wrap;
    logic                arm_req;
    logic [ElapsedW-1:0] delay_ms;
    logic [BcdW-1:0]     bcd_next;
    logic [BcdW-1:0]     disp;
    logic [3:0]          cur_code;
    logic [7:0]          seg;

    // Decimal increment with per-digit ripple carry 9 -> 0.
    function automatic logic [BcdW-1:0] bcd_incr(input logic [BcdW-1:0] v);
        logic [BcdW-1:0] r;
        logic            carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign wrap     = (presc_q == PreW'(CYC_PER_MS - 1));
    assign arm_req  = !ready_click && fire_click;
    assign delay_ms = ElapsedW'(DELAY_MIN_MS + 32'(k_q) * DELAY_STEP_MS);
    assign bcd_next = bcd_incr(bcd_q);

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        presc_d    = presc_q;
        elapsed_d  = elapsed_q;
        bcd_d      = bcd_q;
        cap_d      = cap_q;
        best_d     = best_q;
        new_best_d = new_best_q;
        case (state_q)
            StIdle: begin
                if (arm_req) state_d = StArm;
            end
            StArm: begin
                k_d       = lfsr_q[KWidth-1:0];
                presc_d   = '0;
                elapsed_d = '0;
                bcd_d     = '0;
                state_d   = StWait;
            end
            StWait: begin
                // An early press beats a delay expiring on the same edge.
                if (!fire_click) begin
                    state_d = StFoul;
                end else begin
                    presc_d = wrap ? '0 : presc_q + 1'b1;
                    if (wrap) begin
                        elapsed_d = elapsed_q + 1'b1;
                        if (elapsed_q + 1'b1 == delay_ms) state_d = StGo;
                    end
                end
            end
            StGo: begin
                presc_d = wrap ? '0 : presc_q + 1'b1;
                if (!fire_click) begin
                    state_d = StDone;
                    cap_d   = bcd_q;
                end else if (wrap) begin
                    bcd_d = bcd_next;
                    if (bcd_next == AllNines) begin
                        state_d = StDone;
                        cap_d   = AllNines;
                    end
                end
                if (state_d == StDone) begin
                    new_best_d = (cap_d < best_q);
                    if (cap_d < best_q) best_d = cap_d;
                end
            end
            StDone, StFoul: begin
                if (arm_req) state_d = StArm;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        outleds = 8'h00;
        case (state_q)
            StArm:  outleds = 8'h18;
            StWait: begin
                for (int i = 0; i < 8; i++) outleds[i] = (int'(k_q) >= i);
            end
            StGo:   outleds = 8'hFF;
            StDone: outleds = new_best_q ? 8'h0F : 8'h00;
            StFoul: outleds = 8'hA5;
            default: outleds = 8'h00;
        endcase
    end

    // Per-digit display codes: 0-9 decimal, 4'hF letter F, 4'hA blank.
    always_comb begin
        case (state_q)
            StIdle: disp = best_q;
            StDone: disp = cap_q;
            StFoul: disp = {AllBlank[BcdW-1:4], 4'hF};
            default: disp = bcd_q;
        endcase
    end

    assign cur_code = disp[4*sel_q +: 4];

    always_comb begin
        case (cur_code)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            4'hF:    seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
    end

    always_comb begin
        for (int i = 0; i < int'(DIGITS); i++) anodes[i] = (sel_q != SelW'(i));
    end

    assign cathodes     = cathodes_q;
    assign result_valid = (state_q == StDone);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            lfsr_q     <= LfsrSeed;
            k_q        <= '0;
            presc_q    <= '0;
            elapsed_q  <= '0;
            bcd_q      <= '0;
            cap_q      <= '0;
            best_q     <= AllNines;
            new_best_q <= 1'b0;
            scan_q     <= '0;
            sel_q      <= '0;
            cathodes_q <= 8'hFF;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            k_q        <= k_d;
            presc_q    <= presc_d;
            elapsed_q  <= elapsed_d;
            bcd_q      <= bcd_d;
            cap_q      <= cap_d;
            best_q     <= best_d;
            new_best_q <= new_best_d;
            cathodes_q <= seg;
            if (scan_q == ScanW'(SCAN_CYC - 1)) begin
                scan_q <= '0;
                sel_q  <= (sel_q == SelW'(DIGITS - 1)) ? '0 : sel_q + 1'b1;
            end else begin
                scan_q <= scan_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reflex_timer_gen.sv
// Randomized bench for reflex_timer_gen: stimulus pushes expected results, a monitor checks them.
module tb_reflex_timer_gen;

    localparam int unsigned CycPerMs = 4;
    localparam int unsigned Digits   = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ready_click = 1'b1;
    logic       fire_click = 1'b1;
    logic [2:0] anodes;
    logic [7:0] cathodes;
    logic [7:0] outleds;
    logic       result_valid;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int value;
        bit nb;
    } exp_t;

    exp_t        sb_q[$];
    int          best_m = 999;
    logic [15:0] lfsr_m;

    always #5 clk = ~clk;

    reflex_timer_gen #(
        .CYC_PER_MS   (CycPerMs),
        .DIGITS       (Digits),
        .DELAY_MIN_MS (2),
        .DELAY_STEP_MS(1),
        .DELAY_STEPS  (4),
        .SCAN_CYC     (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ready_click (ready_click),
        .fire_click  (fire_click),
        .anodes      (anodes),
        .cathodes    (cathodes),
        .outleds     (outleds),
        .result_valid(result_valid)
    );

    // Reference random source: the 16-bit Fibonacci LFSR stepped once per clock.
    always @(posedge clk or posedge reset) begin
        if (reset) lfsr_m <= 16'hACE1;
        else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int seg_of(input int v);
        case (v)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            15: return 8'h8E;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic int digit_of(input int v, input int d);
        int p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return (v / p) % 10;
    endfunction

    // Wait for digit d to be the active anode, then read its cathodes one cycle later.
    task automatic read_digit(input int d, output int cath, output int ok);
        logic [2:0] pat;
        pat  = 3'b111;
        pat[d] = 1'b0;
        ok   = 0;
        cath = 0;
        for (int i = 0; i < 64 && ok == 0; i++) begin
            @(negedge clk);
            if (anodes == pat) begin
                @(negedge clk);
                cath = int'(cathodes);
                ok   = 1;
            end
        end
    endtask

    task automatic check_display(input string name, input int c0, input int c1, input int c2);
        int c, ok;
        int want[3];
        want[0] = c0;
        want[1] = c1;
        want[2] = c2;
        for (int d = 0; d < 3; d++) begin
            read_digit(d, c, ok);
            check({name, "_scan"}, ok, 1);
            check(name, c, want[d]);
        end
    endtask

    task automatic arm(output int k);
        ready_click = 1'b0;
        fire_click  = 1'b1;
        @(negedge clk);
        ready_click = 1'b1;
        check("arm_leds", outleds, 8'h18);
        k = int'(lfsr_m[1:0]);
        @(negedge clk);
        check("wait_leds", outleds, (1 << (k + 1)) - 1);
    endtask

    task automatic run_trial(input int t, input bit press);
        int   k, d, v;
        exp_t e;
        repeat ($urandom_range(0, 7)) @(negedge clk);
        arm(k);
        d = 2 + k;
        repeat (4 * d - 1) @(negedge clk);
        check("wait_before_go", outleds, (1 << (k + 1)) - 1);
        @(negedge clk);
        check("go_leds", outleds, 8'hFF);
        check("go_not_valid", result_valid, 0);
        v = press ? t : 999;
        e.value = v;
        e.nb    = (v < best_m);
        if (e.nb) best_m = v;
        sb_q.push_back(e);
        if (press) begin
            repeat (4 * t) @(negedge clk);
            fire_click = 1'b0;
            @(negedge clk);
            fire_click = 1'b1;
        end else begin
            repeat (4 * 999) @(negedge clk);
        end
        check("done_valid", result_valid, 1);
        repeat (100) @(negedge clk);
    endtask

    task automatic foul_trial();
        int k;
        repeat ($urandom_range(0, 5)) @(negedge clk);
        arm(k);
        repeat ($urandom_range(0, 4 * (2 + k) - 2)) @(negedge clk);
        fire_click = 1'b0;
        @(negedge clk);
        fire_click = 1'b1;
        check("foul_leds", outleds, 8'hA5);
        check("foul_not_valid", result_valid, 0);
        check_display("foul_digit", 8'h8E, 8'hFF, 8'hFF);
        // Re-arm from FOUL, then foul again straight away in WAIT.
        arm(k);
        fire_click = 1'b0;
        @(negedge clk);
        fire_click = 1'b1;
        check("refoul_leds", outleds, 8'hA5);
    endtask

    // Scoreboard monitor: checks each result as DONE is entered.
    initial begin
        bit   prev = 1'b0;
        exp_t e;
        int   c, ok;
        forever begin
            @(negedge clk);
            if (result_valid && !prev && !reset) begin
                check("sb_has_entry", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("done_leds", outleds, e.nb ? 8'h0F : 8'h00);
                    for (int d = 0; d < 3; d++) begin
                        read_digit(d, c, ok);
                        check("done_digit_scan", ok, 1);
                        check("done_digit", c, seg_of(digit_of(e.value, d)));
                    end
                end
            end
            prev = result_valid;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) @(negedge clk);
        check("rst_leds", outleds, 8'h00);
        check("rst_valid", result_valid, 0);
        check("rst_anodes", anodes, 3'b110);
        check("rst_cathodes", cathodes, 8'hFF);
        reset = 1'b0;

        check_display("idle_best", 8'h90, 8'h90, 8'h90);
        ready_click = 1'b0;
        fire_click  = 1'b0;
        @(negedge clk);
        check("idle_both_low", outleds, 8'h00);
        ready_click = 1'b1;
        @(negedge clk);
        check("idle_fire_low", outleds, 8'h00);
        fire_click = 1'b1;
        @(negedge clk);
        check("idle_hold", outleds, 8'h00);

        run_trial(37, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        best_m = 999;
        check_display("best_cleared", 8'h90, 8'h90, 8'h90);

        run_trial(50, 1'b1);
        run_trial(80, 1'b1);
        run_trial(60, 1'b1);
        run_trial(50, 1'b1);
        run_trial(0, 1'b1);
        foul_trial();
        for (int i = 0; i < 5; i++) run_trial($urandom_range(1, 120), 1'b1);
        run_trial(0, 1'b0);

        arm(k);
        repeat ($urandom_range(1, 4 * (2 + k) - 2)) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midwait_rst_leds", outleds, 8'h00);
        check("midwait_rst_valid", result_valid, 0);
        check("midwait_rst_anodes", anodes, 3'b110);
        check("midwait_rst_cathodes", cathodes, 8'hFF);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("post_rst_idle", outleds, 8'h00);
        check("post_rst_valid", result_valid, 0);

        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
